// File: rtl/ring_router_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ring_router_mux                                               |
// | Purpose  : Worm-granular round-robin merge of pass-through ring traffic  |
// |            and local injection into a registered output FIFO.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

package dii_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;
endpackage

module ring_router_mux
    import dii_pkg::*;
#(
    parameter int BUFFER_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_ring,
    output logic    in_ring_ready,
    input  dii_flit in_local,
    output logic    in_local_ready,
    output dii_flit out_ring,
    input  logic    out_ring_ready
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_LOCK_RING  = 2'd1;
    localparam logic [1:0] c_LOCK_LOCAL = 2'd2;

    localparam logic c_RR_RING  = 1'b0;
    localparam logic c_RR_LOCAL = 1'b1;

    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_MAX = PTR_W'(BUFFER_DEPTH - 1);

    logic [1:0]       state_q,  state_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Each entry holds {data, last}; storage is deliberately not reset.
    logic [16:0] mem_q [BUFFER_DEPTH];

    logic        w_grant_ring;
    logic        w_grant_local;
    logic        w_not_full;
    logic        w_ring_acc;
    logic        w_local_acc;
    logic        w_push;
    logic        w_pop;
    logic [16:0] w_push_entry;

    // Readies are forced low while reset is held so nothing is accepted then.
    assign w_not_full     = (count_q < c_DEPTH);
    assign in_ring_ready  = rst && w_grant_ring  && w_not_full;
    assign in_local_ready = rst && w_grant_local && w_not_full;

    assign w_ring_acc   = in_ring.valid  && in_ring_ready;
    assign w_local_acc  = in_local.valid && in_local_ready;
    assign w_push       = w_ring_acc || w_local_acc;
    assign w_push_entry = w_ring_acc ? {in_ring.data,  in_ring.last}
                                     : {in_local.data, in_local.last};
    assign w_pop        = (count_q != '0) && out_ring_ready;

    assign out_ring = {mem_q[rd_ptr_q], (count_q != '0)};

    // Arbiter state, round-robin pointer and FIFO bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= c_IDLE;
            rr_last_q <= c_RR_LOCAL;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_push_entry;
        end
    end

    // Next-state: a head flit updates rr_last; a non-last head locks the input
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            c_IDLE: begin
                if (w_ring_acc) begin
                    rr_last_d = c_RR_RING;
                    if (!in_ring.last) state_d = c_LOCK_RING;
                end else if (w_local_acc) begin
                    rr_last_d = c_RR_LOCAL;
                    if (!in_local.last) state_d = c_LOCK_LOCAL;
                end
            end
            c_LOCK_RING: begin
                if (w_ring_acc && in_ring.last) state_d = c_IDLE;
            end
            c_LOCK_LOCAL: begin
                if (w_local_acc && in_local.last) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Grant decode: locked input owns the output, otherwise round-robin on ties
    always_comb begin
        w_grant_ring  = 1'b0;
        w_grant_local = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (in_ring.valid && in_local.valid) begin
                    if (rr_last_q == c_RR_LOCAL) w_grant_ring  = 1'b1;
                    else                         w_grant_local = 1'b1;
                end else begin
                    w_grant_ring  = in_ring.valid;
                    w_grant_local = in_local.valid;
                end
            end
            c_LOCK_RING:  w_grant_ring  = 1'b1;
            c_LOCK_LOCAL: w_grant_local = 1'b1;
            default: ;
        endcase
    end

    // FIFO pointer and occupancy update with modulo-depth wrap
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) wr_ptr_d = (wr_ptr_q == c_PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = (rd_ptr_q == c_PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
        if (w_push && !w_pop)      count_d = count_q + 1'b1;
        else if (!w_push && w_pop) count_d = count_q - 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_router_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ring_router_mux                                            |
// | Purpose  : Directed self-checking bench for ring_router_mux.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ring_router_mux;
    import dii_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    dii_flit in_ring;
    dii_flit in_local;
    dii_flit out_ring;
    logic    in_ring_ready;
    logic    in_local_ready;
    logic    out_ring_ready;

    int total = 0;
    int bad   = 0;

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    ring_router_mux #(.BUFFER_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_ring        (in_ring),
        .in_ring_ready  (in_ring_ready),
        .in_local       (in_local),
        .in_local_ready (in_local_ready),
        .out_ring       (out_ring),
        .out_ring_ready (out_ring_ready)
    );

    always #5 clk = ~clk;

    // Record every flit that leaves; inputs are stable from negedge to posedge
    always @(negedge clk) begin
        if (rst && out_ring.valid && out_ring_ready)
            got_q.push_back({out_ring.data, out_ring.last});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both inputs for one cycle, check readies (-1 = not checked), clock
    task automatic step(input string tag,
                        input logic rv, input logic [15:0] rd, input logic rl,
                        input logic lv, input logic [15:0] ld, input logic ll,
                        input int er, input int el);
        in_ring  = '{data: rd, last: rl, valid: rv};
        in_local = '{data: ld, last: ll, valid: lv};
        #1;
        if (er >= 0) chk({tag, ".ring_ready"},  {31'd0, in_ring_ready},  er);
        if (el >= 0) chk({tag, ".local_ready"}, {31'd0, in_local_ready}, el);
        tick();
    endtask

    task automatic idle(input int n);
        in_ring  = '0;
        in_local = '0;
        repeat (n) tick();
    endtask

    task automatic check_q(input string tag);
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, ".flit"}, {15'd0, got_q[i]}, {15'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset with both inputs valid
        rst            = 1'b0;
        out_ring_ready = 1'b1;
        in_ring        = '{data: 16'h0011, last: 1'b0, valid: 1'b1};
        in_local       = '{data: 16'h00A1, last: 1'b0, valid: 1'b1};
        #1;
        chk("rst.out_valid",   {31'd0, out_ring.valid}, 0);
        chk("rst.ring_ready",  {31'd0, in_ring_ready},  0);
        chk("rst.local_ready", {31'd0, in_local_ready}, 0);
        repeat (3) begin
            tick();
            chk("rst.hold_ready", {31'd0, in_ring_ready | in_local_ready}, 0);
            chk("rst.hold_valid", {31'd0, out_ring.valid}, 0);
        end
        rst = 1'b1;

        // Back-to-back tie: ring worm first, then local worm, no interleave
        step("tie1", 1, 16'h0011, 0, 1, 16'h00A1, 0, 1, 0);
        step("tie2", 1, 16'h0022, 0, 1, 16'h00A1, 0, 1, 0);
        step("tie3", 1, 16'h0033, 1, 1, 16'h00A1, 0, 1, 0);
        step("tie4", 0, 16'h0000, 0, 1, 16'h00A1, 0, 0, 1);
        step("tie5", 0, 16'h0000, 0, 1, 16'h00A2, 1, 0, 1);
        idle(3);
        exp_q.push_back({16'h0011, 1'b0});
        exp_q.push_back({16'h0022, 1'b0});
        exp_q.push_back({16'h0033, 1'b1});
        exp_q.push_back({16'h00A1, 1'b0});
        exp_q.push_back({16'h00A2, 1'b1});
        check_q("tie.out");

        // Single-flit worms alternate every cycle
        step("rr1", 1, 16'h1000, 1, 1, 16'h2000, 1, 1, 0);
        step("rr2", 1, 16'h1001, 1, 1, 16'h2000, 1, 0, 1);
        step("rr3", 1, 16'h1001, 1, 1, 16'h2001, 1, 1, 0);
        step("rr4", 1, 16'h1002, 1, 1, 16'h2001, 1, 0, 1);
        step("rr5", 1, 16'h1002, 1, 1, 16'h2002, 1, 1, 0);
        chk("rr.out_valid", {31'd0, out_ring.valid}, 1);
        step("rr6", 1, 16'h1003, 1, 1, 16'h2002, 1, 0, 1);
        idle(3);
        exp_q.push_back({16'h1000, 1'b1});
        exp_q.push_back({16'h2000, 1'b1});
        exp_q.push_back({16'h1001, 1'b1});
        exp_q.push_back({16'h2001, 1'b1});
        exp_q.push_back({16'h1002, 1'b1});
        exp_q.push_back({16'h2002, 1'b1});
        check_q("rr.out");

        // Full FIFO under downstream stall
        out_ring_ready = 1'b0;
        step("full1", 1, 16'h3000, 1, 0, 16'h0, 0, 1, 0);
        step("full2", 1, 16'h3001, 1, 0, 16'h0, 0, 1, 0);
        step("full3", 1, 16'h3002, 1, 0, 16'h0, 0, 0, 0);
        chk("full.count",     {30'd0, dut.count_q}, 2);
        chk("full.out_valid", {31'd0, out_ring.valid}, 1);
        chk("full.out_data",  {16'd0, out_ring.data}, 32'h3000);
        step("full4", 1, 16'h3002, 1, 0, 16'h0, 0, 0, 0);
        chk("full.stable",    {15'd0, out_ring.data, out_ring.last}, {15'd0, 16'h3000, 1'b1});
        out_ring_ready = 1'b1;
        step("full5", 1, 16'h3002, 1, 0, 16'h0, 0, 0, 0);
        step("full6", 1, 16'h3002, 1, 0, 16'h0, 0, 1, 0);
        step("full7", 1, 16'h3003, 1, 0, 16'h0, 0, 1, 0);
        idle(3);
        exp_q.push_back({16'h3000, 1'b1});
        exp_q.push_back({16'h3001, 1'b1});
        exp_q.push_back({16'h3002, 1'b1});
        exp_q.push_back({16'h3003, 1'b1});
        check_q("full.out");

        // Local head then valid drop: lock must hold against ring
        step("stall0", 1, 16'h4000, 0, 1, 16'h0100, 0, 0, 1);
        repeat (5) step("stall", 1, 16'h4000, 0, 0, 16'h0000, 0, 0, -1);
        step("stall6", 1, 16'h4000, 0, 1, 16'h0200, 1, 0, 1);
        step("stall7", 1, 16'h4000, 0, 0, 16'h0000, 0, 1, 0);
        step("stall8", 1, 16'h4001, 1, 0, 16'h0000, 0, 1, 0);
        idle(3);
        exp_q.push_back({16'h0100, 1'b0});
        exp_q.push_back({16'h0200, 1'b1});
        exp_q.push_back({16'h4000, 1'b0});
        exp_q.push_back({16'h4001, 1'b1});
        check_q("stall.out");

        // Asynchronous reset in the middle of a 4-flit ring worm
        step("arst1", 1, 16'h5000, 0, 0, 16'h0, 0, 1, 0);
        step("arst2", 1, 16'h5001, 0, 0, 16'h0, 0, 1, 0);
        in_ring = '{data: 16'h5002, last: 1'b0, valid: 1'b1};
        #2;
        rst = 1'b0;
        #1;
        chk("arst.ring_ready", {31'd0, in_ring_ready}, 0);
        chk("arst.out_valid",  {31'd0, out_ring.valid}, 0);
        in_ring = '0;
        tick();
        tick();
        rst = 1'b1;
        step("arst3", 0, 16'h0, 0, 1, 16'h0ABC, 1, 0, 1);
        chk("arst.new_flit", {15'd0, out_ring.valid, out_ring.data}, {15'd0, 1'b1, 16'h0ABC});
        idle(1);
        chk("arst.alone", {31'd0, out_ring.valid}, 0);
        idle(2);
        exp_q.push_back({16'h5000, 1'b0});
        exp_q.push_back({16'h0ABC, 1'b1});
        check_q("arst.out");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
